// File: rtl/exp3_fluxo_dados_pkg.sv
// Shared widths and ROM contents for the experiment-3 datapath.
// The bench keeps its own table of the expected ROM words.
package exp3_fluxo_dados_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    // Address 0 sits in the least-significant nibble.
    localparam logic [DEPTH*DATA_W-1:0] ROM_INIT = {
        4'h4, 4'h1, 4'h8, 4'h8, 4'h4, 4'h4, 4'h2, 4'h2,
        4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1
    };

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] addr);
        return ROM_INIT[addr*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/exp3_fluxo_dados_rom.sv
// 16x4 asynchronous-read ROM.
// Contents come from the shared package.
module exp3_fluxo_dados_rom
    import exp3_fluxo_dados_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    always_comb begin
        o_data = rom_word(i_addr);
    end

endmodule

// File: rtl/exp3_fluxo_dados.sv
// Datapath of the memory-sequence game: address counter, switch register,
// ROM and an equality comparator, with debug taps for the board displays.
module exp3_fluxo_dados
    import exp3_fluxo_dados_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              zeraC,
    input  logic              contaC,
    input  logic              zeraR,
    input  logic              registraR,
    input  logic [DATA_W-1:0] chaves,
    output logic              chavesIgualMemoria,
    output logic              fimC,
    output logic [ADDR_W-1:0] db_contagem,
    output logic [DATA_W-1:0] db_chaves,
    output logic [DATA_W-1:0] db_memoria
);

    logic [ADDR_W-1:0] r_contagem;
    logic [DATA_W-1:0] r_chaves;
    logic [DATA_W-1:0] w_memoria;

    // Clear wins over count; the 4-bit add wraps 15 back to 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_contagem <= '0;
        end else if (zeraC) begin
            r_contagem <= '0;
        end else if (contaC) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_chaves <= '0;
        end else if (zeraR) begin
            r_chaves <= '0;
        end else if (registraR) begin
            r_chaves <= chaves;
        end
    end

    exp3_fluxo_dados_rom u_rom (
        .i_addr (r_contagem),
        .o_data (w_memoria)
    );

    // Compares the captured switches, not the live ones.
    assign chavesIgualMemoria = (r_chaves == w_memoria);
    assign fimC               = (r_contagem == ADDR_W'(DEPTH - 1));
    assign db_contagem        = r_contagem;
    assign db_chaves          = r_chaves;
    assign db_memoria         = w_memoria;

endmodule

// File: tb/tb_exp3_fluxo_dados.sv
// Self-checking bench for exp3_fluxo_dados: a bench-side model pushes expected
// outputs to a scoreboard queue, and each test pops and compares them.
module tb_exp3_fluxo_dados;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       zeraC, contaC, zeraR, registraR;
    logic [3:0] chaves;
    logic       chavesIgualMemoria, fimC;
    logic [3:0] db_contagem, db_chaves, db_memoria;

    typedef struct {
        string       name;
        logic [13:0] out;   // {igual, fim, contagem, chaves, memoria}
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] m_cnt, m_reg;
    logic [3:0] rom_ref [16];

    always #5 clock = ~clock;

    exp3_fluxo_dados dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .zeraC              (zeraC),
        .contaC             (contaC),
        .zeraR              (zeraR),
        .registraR          (registraR),
        .chaves             (chaves),
        .chavesIgualMemoria (chavesIgualMemoria),
        .fimC               (fimC),
        .db_contagem        (db_contagem),
        .db_chaves          (db_chaves),
        .db_memoria         (db_memoria)
    );

    function automatic logic [13:0] model_out(input logic [3:0] c, input logic [3:0] r);
        return {r == rom_ref[c], c == 4'd15, c, r, rom_ref[c]};
    endfunction

    function automatic logic [13:0] dut_out();
        return {chavesIgualMemoria, fimC, db_contagem, db_chaves, db_memoria};
    endfunction

    task automatic push_exp(input string name);
        exp_t e;
        e.name = name;
        e.out  = model_out(m_cnt, m_reg);
        sb.push_back(e);
    endtask

    // One clock of stimulus; the model follows the same priority rules.
    task automatic step(input logic zc, input logic cc, input logic zr, input logic rr,
                        input logic [3:0] ch, input string name);
        @(negedge clock);
        zeraC = zc; contaC = cc; zeraR = zr; registraR = rr; chaves = ch;
        @(posedge clock);
        if (zc)      m_cnt = 4'd0;
        else if (cc) m_cnt = m_cnt + 4'd1;
        if (zr)      m_reg = 4'd0;
        else if (rr) m_reg = ch;
        #1;
        push_exp(name);
        zeraC = 1'b0; contaC = 1'b0; zeraR = 1'b0; registraR = 1'b0;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [13:0] got;
        reset_n = 1'b0;
        #12;
        m_cnt = 4'd0; m_reg = 4'd0;
        push_exp("reset_initial");
        e = sb.pop_front(); got = dut_out(); n_vec++;
        if (got !== e.out) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, got, e.out);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 4'h5, "reset_prep");
        while (sb.size() > 0) begin
            e = sb.pop_front(); got = dut_out(); n_vec++;
            if (got !== e.out && sb.size() == 0) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", e.name, got, e.out);
            end
        end
        // Drop reset between edges; outputs must clear without a clock.
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        m_cnt = 4'd0; m_reg = 4'd0;
        push_exp("reset_async");
        e = sb.pop_front(); got = dut_out(); n_vec++;
        if (got !== e.out) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, got, e.out);
        end
        #1 reset_n = 1'b1;
    endtask

    task automatic test_clear();
        exp_t        e;
        logic [13:0] got;
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, "clear_both");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h1, "clear_no_load");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (sb.size() == 0) begin
                got = dut_out(); n_vec++;
                if (got !== e.out || got !== 14'b0_0_0000_0000_0001) begin
                    n_err++;
                    $display("FAIL %s: got %b expected %b", e.name, got, e.out);
                end
            end
        end
    endtask

    task automatic test_load_compare();
        exp_t        e;
        logic [13:0] got;
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'h1, "load_0001");
        e = sb.pop_front(); got = dut_out(); n_vec++;
        if (got !== e.out) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, got, e.out);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, "count_to_1");
        e = sb.pop_front(); got = dut_out(); n_vec++;
        if (got !== e.out) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, got, e.out);
        end
    endtask

    task automatic test_second_word();
        exp_t        e;
        logic [13:0] got;
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'h2, "load_0010");
        e = sb.pop_front(); got = dut_out(); n_vec++;
        if (got !== e.out) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, got, e.out);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, "count_to_2");
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'h8, "load_1000");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (sb.size() == 0) begin
                got = dut_out(); n_vec++;
                if (got !== e.out) begin
                    n_err++;
                    $display("FAIL %s: got %b expected %b", e.name, got, e.out);
                end
            end
        end
    endtask

    // Walk every remaining address, checking each ROM word, then wrap.
    task automatic test_wrap();
        exp_t        e;
        logic [13:0] got;
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, $sformatf("walk_%0d", i + 3));
            e = sb.pop_front(); got = dut_out(); n_vec++;
            if (got !== e.out) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", e.name, got, e.out);
            end
        end
        n_vec++;
        if (db_contagem !== 4'd15 || fimC !== 1'b1 || db_memoria !== 4'b0100) begin
            n_err++;
            $display("FAIL at_end: got cnt=%h fim=%b mem=%b expected cnt=f fim=1 mem=0100",
                     db_contagem, fimC, db_memoria);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, "wrap_to_0");
        e = sb.pop_front(); got = dut_out(); n_vec++;
        if (got !== e.out) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, got, e.out);
        end
    endtask

    task automatic test_priority();
        exp_t        e;
        logic [13:0] got;
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'hA, "prio_prep_a");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, "prio_prep_b");
        e = sb.pop_front(); e = sb.pop_front(); got = dut_out(); n_vec++;
        if (got !== e.out) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, got, e.out);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, "prio_clear_wins");
        e = sb.pop_front(); got = dut_out(); n_vec++;
        if (got !== e.out || db_contagem !== 4'd0 || db_chaves !== 4'd0) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, got, e.out);
        end
        // Hold: no controls, live chaves must not leak into the register.
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h1, "hold");
        e = sb.pop_front(); got = dut_out(); n_vec++;
        if (got !== e.out) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, got, e.out);
        end
    endtask

    initial begin
        rom_ref = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                    4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
        zeraC = 1'b0; contaC = 1'b0; zeraR = 1'b0; registraR = 1'b0; chaves = 4'h0;
        test_reset();
        test_clear();
        test_load_compare();
        test_second_word();
        test_wrap();
        test_priority();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
